ray_coord_gen: RTL and testbench



---
 rtl/ray_coord_pkg.sv | 8 +
 rtl/coord_axis_counter.sv | 33 +++
 rtl/ray_coord_gen.sv | 55 +++++
 tb/tb_ray_coord_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ray_coord_pkg.sv
// ray_coord_pkg: shared Q8.24 constants and FSM state type for the ray coordinate generator.
package ray_coord_pkg;
  localparam int FRAC_BITS = 24;
  localparam logic [31:0] DEF_STEP = 32'h0020_0000;
  localparam logic [31:0] DEF_CENTER_X = 32'h2800_0000;
  localparam logic [31:0] DEF_CENTER_Y = 32'h1E00_0000;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/coord_axis_counter.sv
// coord_axis_counter: wrapping index with a Q8.24 accumulator and a centred offset, all advanced together.
module coord_axis_counter
  import ray_coord_pkg::*;
#(
  parameter int N = 640,
  parameter logic [31:0] STEP = DEF_STEP,
  parameter logic [31:0] CENTER = DEF_CENTER_X,
  parameter bit FLIP = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output logic [$clog2(N)-1:0] cnt,
  output logic [31:0] acc,
  output logic [31:0] rel,
  output logic wrap
);
  logic [31:0] acc_nx;
  assign wrap = cnt == ($clog2(N))'(N - 1);
  assign acc_nx = wrap ? '0 : acc + STEP;
  // FLIP selects CENTER - acc (screen y grows down, v grows up) instead of acc - CENTER
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      rel <= FLIP ? CENTER : 32'd0 - CENTER;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      acc <= acc_nx;
      rel <= FLIP ? CENTER - acc_nx : acc_nx - CENTER;
    end
  end
endmodule

// File: rtl/ray_coord_gen.sv
// ray_coord_gen: raster-order pixel coordinate source with valid/ready output and frame-level enable gating.
module ray_coord_gen
  import ray_coord_pkg::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter logic [31:0] STEP = DEF_STEP,
  parameter logic [31:0] CENTER_X = DEF_CENTER_X,
  parameter logic [31:0] CENTER_Y = DEF_CENTER_Y
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic out_ready,
  output logic out_valid,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [31:0] out_u,
  output logic [31:0] out_v,
  output logic out_sof,
  output logic out_eol,
  output logic frame_done,
  output logic busy
);
  state_t state, state_nx;
  logic hs, col_wrap, row_wrap, last;
  logic [$clog2(H_RES)-1:0] col;
  logic [$clog2(V_RES)-1:0] row;
  assign hs = out_valid & out_ready;
  assign last = col_wrap & row_wrap;
  coord_axis_counter #(.N(H_RES), .STEP(STEP), .CENTER(CENTER_X), .FLIP(1'b0)) u_col (
    .clk(clk), .rst(rst), .inc(hs), .cnt(col), .acc(out_x), .rel(out_u), .wrap(col_wrap)
  );
  coord_axis_counter #(.N(V_RES), .STEP(STEP), .CENTER(CENTER_Y), .FLIP(1'b1)) u_row (
    .clk(clk), .rst(rst), .inc(hs & col_wrap), .cnt(row), .acc(out_y), .rel(out_v), .wrap(row_wrap)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      frame_done <= 1'b0;
    end else begin
      state <= state_nx;
      frame_done <= hs & last;
    end
  end
  // counters already sit at (0,0) after the last pixel, so restarting only needs the state change
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (enable ? RUN : IDLE) : ((hs && last && !enable) ? IDLE : RUN);
  end
  assign out_valid = state == RUN;
  assign busy = state == RUN;
  assign out_sof = out_valid && col == '0 && row == '0;
  assign out_eol = out_valid && col_wrap;
endmodule

// File: tb/tb_ray_coord_gen.sv
// tb_ray_coord_gen: scoreboard bench for ray_coord_gen on a 4x3 frame plus a default-size first-beat check.
module tb_ray_coord_gen;
  localparam int H = 4;
  localparam int V = 3;
  localparam logic [31:0] ST = 32'h0020_0000;
  localparam logic [31:0] CX = 32'h0040_0000;
  localparam logic [31:0] CY = 32'h0030_0000;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, out_ready = 1'b0;
  logic out_valid, out_sof, out_eol, frame_done, busy;
  logic [31:0] out_x, out_y, out_u, out_v;
  logic b_enable = 1'b0, b_ready = 1'b0;
  logic b_valid, b_sof, b_eol, b_fd, b_busy;
  logic [31:0] b_x, b_y, b_u, b_v;

  ray_coord_gen #(.H_RES(H), .V_RES(V), .STEP(ST), .CENTER_X(CX), .CENTER_Y(CY)) dut (
    .clk(clk), .rst(rst), .enable(enable), .out_ready(out_ready), .out_valid(out_valid),
    .out_x(out_x), .out_y(out_y), .out_u(out_u), .out_v(out_v), .out_sof(out_sof),
    .out_eol(out_eol), .frame_done(frame_done), .busy(busy)
  );
  ray_coord_gen dut_def (
    .clk(clk), .rst(rst), .enable(b_enable), .out_ready(b_ready), .out_valid(b_valid),
    .out_x(b_x), .out_y(b_y), .out_u(b_u), .out_v(b_v), .out_sof(b_sof),
    .out_eol(b_eol), .frame_done(b_fd), .busy(b_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x, y, u, v;
    logic sof, eol, last;
  } beat_t;
  beat_t q[$];
  int n_chk = 0, n_fail = 0, hs_cnt = 0;
  logic m_run = 1'b0, exp_fd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    beat_t b;
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        b.x = 32'(c) * ST;
        b.y = 32'(r) * ST;
        b.u = b.x - CX;
        b.v = CY - b.y;
        b.sof = (c == 0) && (r == 0);
        b.eol = c == H - 1;
        b.last = (c == H - 1) && (r == V - 1);
        q.push_back(b);
      end
  endtask

  task automatic chk_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_x", out_x, 0);
    chk("rst_y", out_y, 0);
    chk("rst_u", out_u, 32'd0 - CX);
    chk("rst_v", out_v, CY);
    chk("rst_sof", out_sof, 0);
    chk("rst_eol", out_eol, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
  endtask

  // one clock: drive inputs at the negedge, check against the model, then advance to the next negedge
  task automatic tick(input logic en, input logic rdy);
    beat_t e;
    enable = en;
    out_ready = rdy;
    #1;
    chk("valid", out_valid, m_run);
    chk("busy", busy, m_run);
    chk("frame_done", frame_done, exp_fd);
    exp_fd = 1'b0;
    if (m_run) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL scoreboard: observed beat with empty queue expected none");
      end else begin
        e = q[0];
        chk("x", out_x, e.x);
        chk("y", out_y, e.y);
        chk("u", out_u, e.u);
        chk("v", out_v, e.v);
        chk("sof", out_sof, e.sof);
        chk("eol", out_eol, e.eol);
        if (rdy) begin
          void'(q.pop_front());
          hs_cnt++;
          if (e.last) begin
            exp_fd = 1'b1;
            chk("beats_per_frame", hs_cnt, H * V);
            hs_cnt = 0;
            if (en) push_frame();
            else m_run = 1'b0;
          end
        end
      end
    end else begin
      chk("idle_sof", out_sof, 0);
      chk("idle_eol", out_eol, 0);
      if (en) begin
        push_frame();
        m_run = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int bound, input bit rnd);
    int k = 0;
    while (m_run && k < bound) begin
      tick(1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      k++;
    end
    chk("drain_timeout", m_run, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk_reset();
    chk("def_rst_u", b_u, 32'hD800_0000);
    chk("def_rst_v", b_v, 32'h1E00_0000);
    @(negedge clk);
    rst = 1'b0;
    b_enable = 1'b1;
    @(negedge clk);
    b_enable = 1'b0;
    #1;
    chk("def_valid", b_valid, 1);
    chk("def_sof", b_sof, 1);
    chk("def_x0", b_x, 0);
    chk("def_u0", b_u, 32'hD800_0000);
    chk("def_v0", b_v, 32'h1E00_0000);
    @(negedge clk);
    #1;
    chk("def_stall_u0", b_u, 32'hD800_0000);
    @(negedge clk);
    tick(0, 1);
    tick(0, 1);
    tick(1, 1);
    drain(40, 0);
    tick(0, 1);
    tick(0, 1);
    repeat (24) tick(1, 1);
    drain(40, 0);
    tick(0, 1);
    tick(1, 1);
    repeat (5) tick(1, 1);
    drain(40, 0);
    tick(0, 1);
    for (int i = 0; i < 40; i++) tick(1, 1'($urandom_range(0, 1)));
    drain(400, 1);
    tick(0, 1);
    tick(1, 1);
    repeat (6) tick(1, 1);
    tick(1, 0);
    tick(1, 0);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset();
    q.delete();
    m_run = 1'b0;
    exp_fd = 1'b0;
    hs_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    tick(1, 1);
    drain(40, 0);
    tick(0, 1);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
